brr_frame_reader: RTL

Read-side controller for the bit-reversal ping-pong reorder buffer. It waits until the buffer reports a complete frame and drives the buffer read strobe for exactly one frame. It absorbs the buffer's one-cycle read latency in a 2-entry skid FIFO and presents the natural-order words as a valid/ready stream with frame markers. It sits between the reorder buffer and downstream FFT post-processing that can apply backpressure.

---
 rtl/brr_frame_reader.sv | 116 +++++++++++
 1 files changed

// File: rtl/brr_frame_reader.sv
// Read-side controller for the bit-reversal ping-pong reorder buffer: reads one frame
// per request, absorbs the one-cycle read latency in a 2-entry skid FIFO, streams out.
module brr_frame_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  buf_empty,
   output logic                  buf_rd_en,
   input  logic [DATA_WIDTH-1:0] buf_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_sof,
   output logic                  m_eof,
   output logic [ADDR_WIDTH-1:0] m_idx,
   output logic [15:0]           frame_cnt,
   output logic                  busy
);

   localparam int                  DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LAST_RD  = (ADDR_WIDTH+1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

   state_t                  r_state, w_state_nxt;
   logic [ADDR_WIDTH:0]     r_rd_cnt;
   logic                    r_in_flight_p1;
   logic [1:0]              r_occ;
   logic [ADDR_WIDTH-1:0]   r_out_idx;
   logic [DATA_WIDTH-1:0]   r_fifo [2];
   logic                    r_head;
   logic                    r_tail;
   logic [15:0]             r_frame_cnt;

   logic                    w_pop;
   logic                    w_push;
   logic                    w_rd_en;
   logic                    w_eof_xfer;
   logic [1:0]              w_credit;

   // Credit check: a read may issue only if its word is guaranteed a FIFO slot
   // once it lands, counting the word already in flight and this cycle's pop.
   always_comb begin
      w_pop      = m_valid & m_ready;
      w_push     = r_in_flight_p1;
      w_credit   = r_occ + {1'b0, r_in_flight_p1};
      w_rd_en    = (r_state == S_STREAM) && !r_rd_cnt[ADDR_WIDTH]
                   && (w_credit <= (w_pop ? 2'd2 : 2'd1));
      w_eof_xfer = w_pop & (r_out_idx == LAST_IDX);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (!buf_empty) w_state_nxt = S_STREAM;
         S_STREAM: if (w_rd_en && (r_rd_cnt == LAST_RD)) w_state_nxt = S_DRAIN;
         S_DRAIN:  if (w_eof_xfer) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // p0 -> p1: read issued, word arrives on buf_data one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_rd_cnt       <= '0;
         r_in_flight_p1 <= 1'b0;
         r_occ          <= 2'd0;
         r_out_idx      <= '0;
         r_head         <= 1'b0;
         r_tail         <= 1'b0;
         r_frame_cnt    <= 16'd0;
      end else begin
         r_state        <= w_state_nxt;
         r_in_flight_p1 <= w_rd_en;
         if (r_state == S_IDLE)
            r_rd_cnt <= '0;
         else if (w_rd_en)
            r_rd_cnt <= r_rd_cnt + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
         if (w_push)
            r_tail <= ~r_tail;
         if (w_pop) begin
            r_head    <= ~r_head;
            r_out_idx <= r_out_idx + 1'b1;
         end
         if (w_eof_xfer)
            r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   // p1 -> p2: landed word captured into the skid FIFO
   always_ff @(posedge clk) begin
      if (rst)
         r_fifo <= '{default: '0};
      else if (w_push)
         r_fifo[r_tail] <= buf_data;
   end

   assign buf_rd_en = w_rd_en;
   assign m_valid   = (r_occ != 2'd0);
   assign m_data    = r_fifo[r_head];
   assign m_idx     = r_out_idx;
   assign m_sof     = m_valid & (r_out_idx == '0);
   assign m_eof     = m_valid & (r_out_idx == LAST_IDX);
   assign frame_cnt = r_frame_cnt;
   assign busy      = (r_state != S_IDLE);

endmodule
